// File: rtl/core_ins_sched.sv
// Instruction scheduler: buffers host instruction words in a FIFO and sequences core runs and host IRQs.
// Optional run counter enabled by defining CORE_INS_SCHED_STAT_EN.
module core_ins_sched #(
  parameter int INS_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INS_WIDTH-1:0] s_axis_ins_tdata,
  input  logic                 s_axis_ins_tlast,
  input  logic                 s_axis_ins_tvalid,
  output logic                 s_axis_ins_tready,
  output logic                 core_valid,
  input  logic                 core_ready,
  input  logic                 core_finish,
  output logic                 core_bit_mode_i,
  output logic                 core_fm_ping_pong_i,
  output logic                 IRQ_REQ,
  input  logic                 IRQ_ACK,
  output logic                 busy,
  output logic [31:0]          run_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_RUN      = 2'b01;
  localparam logic [1:0] OP_RUN_SWAP = 2'b10;
  localparam logic [1:0] OP_HALT     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_IRQ    = 3'd4
  } state_t;

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q;
  logic          push_s, pop_s;
  logic [16:0]   head_s;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          bm_q, bm_d;
  logic          last_q, last_d;
  logic [7:0]    rem_q, rem_d;
  logic          pp_q, pp_d;

  assign push_s = s_axis_ins_tvalid && tready_q;
  assign head_s = mem_q[rd_ptr_q];

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage; data needs no reset because pointers qualify it
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {s_axis_ins_tdata[15:0], s_axis_ins_tlast};
    end
  end

  // FIFO pointers, count and ready; ready tracks the next count so it is low throughout reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      tready_q <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  // Sequencer next-state and instruction register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bm_d    = bm_q;
    last_d  = last_q;
    rem_d   = rem_q;
    pp_d    = pp_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != CW'(0)) begin
          pop_s   = 1'b1;
          last_d  = head_s[0];
          op_d    = head_s[2:1];
          bm_d    = head_s[3];
          rem_d   = head_s[16:9];
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        case (op_q)
          OP_NOP:      state_d = last_q ? ST_IRQ : ST_IDLE;
          OP_HALT:     state_d = ST_IRQ;
          OP_RUN:      state_d = ST_ISSUE;
          OP_RUN_SWAP: begin
            pp_d    = ~pp_q;
            state_d = ST_ISSUE;
          end
          default:     state_d = ST_IDLE;
        endcase
      end
      ST_ISSUE: begin
        if (core_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (core_finish) begin
          if (rem_q != 8'd0) begin
            rem_d   = rem_q - 8'd1;
            state_d = ST_ISSUE;
            if (op_q == OP_RUN_SWAP) begin
              pp_d = ~pp_q;
            end else begin
              pp_d = pp_q;
            end
          end else begin
            state_d = last_q ? ST_IRQ : ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_IRQ: begin
        if (IRQ_ACK) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IRQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      bm_q    <= 1'b0;
      last_q  <= 1'b0;
      rem_q   <= 8'd0;
      pp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bm_q    <= bm_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      pp_q    <= pp_d;
    end
  end

  assign s_axis_ins_tready   = tready_q;
  assign core_valid          = (state_q == ST_ISSUE);
  assign IRQ_REQ             = (state_q == ST_IRQ);
  assign busy                = (state_q != ST_IDLE) || (count_q != CW'(0));
  assign core_bit_mode_i     = bm_q;
  assign core_fm_ping_pong_i = pp_q;

  // Instruction bits [7:3] and everything above bit 15 carry no meaning here
  logic unused_fields_s;
  assign unused_fields_s = &{1'b0, head_s[8:4]};

  generate
    if (INS_WIDTH > 16) begin : g_wide
      logic unused_hi_s;
      assign unused_hi_s = &{1'b0, s_axis_ins_tdata[INS_WIDTH-1:16]};
    end
  endgenerate

`ifdef CORE_INS_SCHED_STAT_EN
  logic [31:0] run_cnt_q;
  logic        fin_acc_s;

  assign fin_acc_s = (state_q == ST_WAIT) && core_finish;

  // Saturating count of completed runs
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= 32'd0;
    end else if (fin_acc_s && (run_cnt_q != 32'hFFFF_FFFF)) begin
      run_cnt_q <= run_cnt_q + 32'd1;
    end
  end

  assign run_cnt = run_cnt_q;
`else
  assign run_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_core_ins_sched.sv
// Directed self-checking bench for core_ins_sched (default FIFO_DEPTH=4, INS_WIDTH=64).
module tb_core_ins_sched;

  logic        clk;
  logic        rst;
  logic [63:0] s_axis_ins_tdata;
  logic        s_axis_ins_tlast;
  logic        s_axis_ins_tvalid;
  logic        s_axis_ins_tready;
  logic        core_valid;
  logic        core_ready;
  logic        core_finish;
  logic        core_bit_mode_i;
  logic        core_fm_ping_pong_i;
  logic        IRQ_REQ;
  logic        IRQ_ACK;
  logic        busy;
  logic [31:0] run_cnt;

`ifdef CORE_INS_SCHED_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;
  int hs0, v0;

  core_ins_sched #(.INS_WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_ins_tdata(s_axis_ins_tdata), .s_axis_ins_tlast(s_axis_ins_tlast),
    .s_axis_ins_tvalid(s_axis_ins_tvalid), .s_axis_ins_tready(s_axis_ins_tready),
    .core_valid(core_valid), .core_ready(core_ready), .core_finish(core_finish),
    .core_bit_mode_i(core_bit_mode_i), .core_fm_ping_pong_i(core_fm_ping_pong_i),
    .IRQ_REQ(IRQ_REQ), .IRQ_ACK(IRQ_ACK), .busy(busy), .run_cnt(run_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (core_valid && core_ready) hs_cnt <= hs_cnt + 1;
    if (core_valid) valid_cycles <= valid_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rc(input int n);
    return STAT ? 32'(n) : 32'd0;
  endfunction

  // Offer one word; upper bits carry junk that must be ignored.
  task automatic send(input logic [15:0] w, input logic last);
    int n = 0;
    s_axis_ins_tdata  = {48'hA5A5_5A5A_F0F0, w};
    s_axis_ins_tlast  = last;
    s_axis_ins_tvalid = 1'b1;
    while (!s_axis_ins_tready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, s_axis_ins_tready}, 32'd1);
    tick();
    s_axis_ins_tvalid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!core_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, core_valid}, 32'd1);
  endtask

  task automatic handshake();
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
  endtask

  task automatic finish_pulse();
    repeat (4) tick();
    core_finish = 1'b1;
    tick();
    core_finish = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic bm, input logic pp);
    wait_valid({tag, "_valid"});
    chk({tag, "_bm"}, {31'd0, core_bit_mode_i}, {31'd0, bm});
    chk({tag, "_pp"}, {31'd0, core_fm_ping_pong_i}, {31'd0, pp});
    handshake();
    finish_pulse();
  endtask

  task automatic ack_irq();
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    s_axis_ins_tdata = 64'd0;
    s_axis_ins_tlast = 1'b0;
    s_axis_ins_tvalid = 1'b0;
    core_ready = 1'b0;
    core_finish = 1'b0;
    IRQ_ACK = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_tready", {31'd0, s_axis_ins_tready}, 32'd0);
    chk("rst_valid", {31'd0, core_valid}, 32'd0);
    chk("rst_irq", {31'd0, IRQ_REQ}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bm", {31'd0, core_bit_mode_i}, 32'd0);
    chk("rst_pp", {31'd0, core_fm_ping_pong_i}, 32'd0);
    chk("rst_runcnt", run_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("tready_after_rst", {31'd0, s_axis_ins_tready}, 32'd1);

    // Single RUN, bit_mode=1, rep=0, last; check 2-cycle issue latency
    hs0 = hs_cnt;
    send(16'h0005, 1'b1);
    chk("t1_valid_idle", {31'd0, core_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_valid_decode", {31'd0, core_valid}, 32'd0);
    tick();
    chk("t1_valid_issue", {31'd0, core_valid}, 32'd1);
    chk("t1_bm", {31'd0, core_bit_mode_i}, 32'd1);
    chk("t1_pp", {31'd0, core_fm_ping_pong_i}, 32'd0);
    handshake();
    chk("t1_valid_wait", {31'd0, core_valid}, 32'd0);
    finish_pulse();
    chk("t1_irq", {31'd0, IRQ_REQ}, 32'd1);
    chk("t1_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("t1_runcnt", run_cnt, rc(1));
    ack_irq();
    chk("t1_irq_clr", {31'd0, IRQ_REQ}, 32'd0);
    chk("t1_busy_clr", {31'd0, busy}, 32'd0);

    // RUN_SWAP rep=2 from reset: ping-pong 1,0,1
    do_reset();
    hs0 = hs_cnt;
    send(16'h0202, 1'b1);
    run_one("t2_r0", 1'b0, 1'b1);
    run_one("t2_r1", 1'b0, 1'b0);
    run_one("t2_r2", 1'b0, 1'b1);
    chk("t2_irq", {31'd0, IRQ_REQ}, 32'd1);
    chk("t2_hs", 32'(hs_cnt - hs0), 32'd3);
    chk("t2_runcnt", run_cnt, rc(3));
    ack_irq();

    // Stray core_finish in IDLE and ISSUE, stray IRQ_ACK in WAIT
    core_finish = 1'b1;
    tick();
    core_finish = 1'b0;
    tick();
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);
    chk("t3_idle_runcnt", run_cnt, rc(3));
    send(16'h0001, 1'b0);
    wait_valid("t3_valid");
    core_finish = 1'b1;
    tick();
    core_finish = 1'b0;
    chk("t3_issue_hold", {31'd0, core_valid}, 32'd1);
    chk("t3_issue_runcnt", run_cnt, rc(3));
    chk("t3_pp", {31'd0, core_fm_ping_pong_i}, 32'd1);
    handshake();
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    chk("t3_wait_busy", {31'd0, busy}, 32'd1);
    chk("t3_wait_irq", {31'd0, IRQ_REQ}, 32'd0);
    chk("t3_wait_valid", {31'd0, core_valid}, 32'd0);
    finish_pulse();
    chk("t3_done_busy", {31'd0, busy}, 32'd0);
    chk("t3_done_irq", {31'd0, IRQ_REQ}, 32'd0);
    chk("t3_runcnt", run_cnt, rc(4));

    // NOP (not last) then HALT: no run, IRQ after HALT
    v0 = valid_cycles;
    send(16'h0000, 1'b0);
    send(16'h0003, 1'b0);
    begin
      int n = 0;
      while (!IRQ_REQ && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t4_irq", {31'd0, IRQ_REQ}, 32'd1);
    chk("t4_no_valid", 32'(valid_cycles - v0), 32'd0);
    ack_irq();
    chk("t4_busy", {31'd0, busy}, 32'd0);

    // Backpressure: five words, one in the instruction register and four filling the FIFO
    send(16'h0005, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0002, 1'b1);
    chk("t5_tready_full", {31'd0, s_axis_ins_tready}, 32'd0);
    s_axis_ins_tdata = 64'hFFFF;
    s_axis_ins_tvalid = 1'b1;
    repeat (3) tick();
    chk("t5_tready_held", {31'd0, s_axis_ins_tready}, 32'd0);
    s_axis_ins_tvalid = 1'b0;
    run_one("t5_w1", 1'b1, 1'b1);
    run_one("t5_w2", 1'b0, 1'b1);
    run_one("t5_w3", 1'b1, 1'b0);
    run_one("t5_w4", 1'b1, 1'b0);
    run_one("t5_w5", 1'b0, 1'b1);
    chk("t5_irq", {31'd0, IRQ_REQ}, 32'd1);
    chk("t5_tready", {31'd0, s_axis_ins_tready}, 32'd1);
    chk("t5_runcnt", run_cnt, rc(9));
    ack_irq();
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // Reset in WAIT with two words queued
    send(16'h0001, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0005, 1'b1);
    wait_valid("t6_valid");
    handshake();
    rst = 1'b1;
    tick();
    chk("t6_tready", {31'd0, s_axis_ins_tready}, 32'd0);
    chk("t6_valid", {31'd0, core_valid}, 32'd0);
    chk("t6_irq", {31'd0, IRQ_REQ}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_bm", {31'd0, core_bit_mode_i}, 32'd0);
    chk("t6_pp", {31'd0, core_fm_ping_pong_i}, 32'd0);
    chk("t6_runcnt", run_cnt, 32'd0);
    rst = 1'b0;
    v0 = valid_cycles;
    core_finish = 1'b1;
    repeat (20) tick();
    core_finish = 1'b0;
    chk("t6_no_valid", 32'(valid_cycles - v0), 32'd0);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);
    chk("t6_tready_after", {31'd0, s_axis_ins_tready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
